// File: rtl/global_pkg.sv
// Shared types and constants for the load/store access unit.
//   mem_size_t  : access size encoding (byte/half/word)
//   lsu_state_t : access unit FSM states
//   CAUSE_*     : RISC-V mcause codes reported on a faulting access
package global_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    BUS   = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_ACCESS      = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_STORE_ACCESS     = 4'd7;

  // Select the misaligned cause for a load or a store.
  function automatic logic [3:0] misaligned_cause(input logic we);
    return we ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
  endfunction

  // Select the access-fault cause for a load or a store.
  function automatic logic [3:0] access_cause(input logic we);
    return we ? CAUSE_STORE_ACCESS : CAUSE_LOAD_ACCESS;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the access unit.
//   size, offset, is_unsigned : access shape
//   wdata                     : LSB-aligned store data
//   dat_i                     : raw Wishbone read word
//   sel_c                     : byte enables
//   dat_o_c                   : lane-replicated store data
//   rdata_c                   : shifted and sign/zero-extended load data
module lsu_align
  import global_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_c,
  output logic [31:0] dat_o_c,
  output logic [31:0] rdata_c
);

  logic [31:0] shifted;

  // Bring the addressed byte lane down to bit 0, then extend per size.
  always_comb begin
    shifted = dat_i >> {offset, 3'b000};
    sel_c   = 4'b1111;
    dat_o_c = wdata;
    rdata_c = shifted;
    case (size)
      MEM_BYTE: begin
        sel_c   = 4'b0001 << offset;
        dat_o_c = {4{wdata[7:0]}};
        rdata_c = is_unsigned ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      MEM_HALF: begin
        sel_c   = 4'b0011 << offset;
        dat_o_c = {2{wdata[15:0]}};
        rdata_c = is_unsigned ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        sel_c   = 4'b1111;
        dat_o_c = wdata;
        rdata_c = shifted;
      end
    endcase
  end

endmodule

// File: rtl/lsu_access_unit.sv
// Load/store access unit: captures one request, checks alignment and the
// PMP verdict, runs a single Wishbone classic transaction and returns
// extended load data or an exception cause.
//   clk, rst (async, active-low)
//   req_*   : request from execute (req_ready combinational in IDLE)
//   pmp_*   : captured address out, same-cycle verdict in
//   resp_*  : one-cycle registered response to writeback
//   wb_*    : Wishbone classic master
// Optional macro LSU_BUS_TIMEOUT_EN adds a bus watchdog of TIMEOUT_CYCLES.
module lsu_access_unit
  import global_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  mem_size_t   req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] pmp_addr,
  input  logic        pmp_illegal,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [3:0]  resp_cause,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  input  logic        wb_err
);

  lsu_state_t  state_q, state_d;
  logic        we_q, we_d, uns_q, uns_d;
  mem_size_t   size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d, resp_fault_q, resp_fault_d;
  logic [3:0]  resp_cause_q, resp_cause_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        wb_cyc_q, wb_cyc_d, wb_we_q, wb_we_d;
  logic [31:0] wb_adr_q, wb_adr_d, wb_dat_o_q, wb_dat_o_d;
  logic [3:0]  wb_sel_q, wb_sel_d;
  logic [3:0]  sel_c;
  logic [31:0] dat_o_c, rdata_c;
  logic        misaligned_c;

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Watchdog counting BUS cycles without termination.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  logic timeout_unused;
  assign timeout_unused = |32'(TIMEOUT_CYCLES);
`endif

  lsu_align u_align (
    .size        (size_q),
    .offset      (addr_q[1:0]),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .dat_i       (wb_dat_i),
    .sel_c       (sel_c),
    .dat_o_c     (dat_o_c),
    .rdata_c     (rdata_c)
  );

  // Half must be 2-byte aligned; word (and the unused encoding) 4-byte aligned.
  always_comb begin
    case (size_q)
      MEM_BYTE: misaligned_c = 1'b0;
      MEM_HALF: misaligned_c = addr_q[0];
      default:  misaligned_c = |addr_q[1:0];
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= MEM_BYTE;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_cause_q <= '0;
      resp_rdata_q <= '0;
      wb_cyc_q     <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_adr_q     <= '0;
      wb_dat_o_q   <= '0;
      wb_sel_q     <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_cause_q <= resp_cause_d;
      resp_rdata_q <= resp_rdata_d;
      wb_cyc_q     <= wb_cyc_d;
      wb_we_q      <= wb_we_d;
      wb_adr_q     <= wb_adr_d;
      wb_dat_o_q   <= wb_dat_o_d;
      wb_sel_q     <= wb_sel_d;
    end
  end

  // Next state; registered outputs are derived from the state being entered.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_fault_d = 1'b0;
    resp_cause_d = '0;
    resp_rdata_d = '0;
`ifdef LSU_BUS_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (misaligned_c) begin
          state_d      = RESP;
          resp_fault_d = 1'b1;
          resp_cause_d = misaligned_cause(we_q);
        end else if (pmp_illegal) begin
          state_d      = RESP;
          resp_fault_d = 1'b1;
          resp_cause_d = access_cause(we_q);
        end else begin
          state_d = BUS;
`ifdef LSU_BUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUS: begin
        // err wins over a simultaneous ack
        if (wb_err) begin
          state_d      = RESP;
          resp_fault_d = 1'b1;
          resp_cause_d = access_cause(we_q);
        end else if (wb_ack) begin
          state_d      = RESP;
          resp_rdata_d = we_q ? '0 : rdata_c;
        end
`ifdef LSU_BUS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d      = RESP;
          resp_fault_d = 1'b1;
          resp_cause_d = access_cause(we_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    wb_cyc_d     = (state_d == BUS);
    wb_we_d      = wb_cyc_d & we_q;
    wb_adr_d     = wb_cyc_d ? {addr_q[31:2], 2'b00} : '0;
    wb_sel_d     = wb_cyc_d ? sel_c : '0;
    wb_dat_o_d   = wb_cyc_d ? dat_o_c : '0;
    resp_valid_d = (state_d == RESP);
  end

  assign req_ready  = (state_q == IDLE);
  assign pmp_addr   = addr_q;
  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_cause = resp_cause_q;
  assign resp_rdata = resp_rdata_q;
  assign wb_cyc     = wb_cyc_q;
  assign wb_stb     = wb_cyc_q;
  assign wb_we      = wb_we_q;
  assign wb_adr     = wb_adr_q;
  assign wb_dat_o   = wb_dat_o_q;
  assign wb_sel     = wb_sel_q;

endmodule

// File: tb/tb_lsu_access_unit.sv
// Self-checking bench for lsu_access_unit: directed cases plus randomized
// transactions checked against a byte-level reference model.
module tb_lsu_access_unit;
  import global_pkg::*;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  mem_size_t   req_size;
  logic [31:0] req_addr, req_wdata, pmp_addr;
  logic        pmp_illegal, force_deny;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [3:0]  resp_cause;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // PMP stand-in: top 16 MiB region is denied, plus a forced deny.
  assign pmp_illegal = force_deny | (pmp_addr[31:24] == 8'hFF);

  lsu_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .pmp_addr(pmp_addr), .pmp_illegal(pmp_illegal),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .resp_cause(resp_cause), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .wb_err(wb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode: 0 ack, 1 err, 2 ack+err together, 3 slave never answers
  task automatic do_tx(input logic we, input mem_size_t sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic deny, input int waits, input logic [31:0] rd,
                       input int mode);
    int nb, off, lat, cyc_idx, bus_n;
    logic mis, ill, early, got, saw, e_fault;
    logic [31:0] e_rdata, e_dato, raw, mask;
    logic [3:0]  e_sel, e_cause;

    nb    = (sz == MEM_BYTE) ? 1 : (sz == MEM_HALF) ? 2 : 4;
    off   = int'(addr[1:0]);
    mis   = (off % nb) != 0;
    ill   = deny || (addr[31:24] == 8'hFF);
    early = mis || ill;
    e_sel = 4'(((1 << nb) - 1) << off);
    for (int i = 0; i < 4; i++) e_dato[8*i +: 8] = wdata[8*(i % nb) +: 8];
    raw     = rd >> (8 * off);
    mask    = (nb == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * nb)) - 1);
    e_rdata = raw & mask;
    if (!uns && nb < 4 && e_rdata[8*nb-1]) e_rdata = e_rdata | ~mask;
    if (mis)            begin e_fault = 1'b1; e_cause = we ? 4'd6 : 4'd4; end
    else if (ill)       begin e_fault = 1'b1; e_cause = we ? 4'd7 : 4'd5; end
    else if (mode != 0) begin e_fault = 1'b1; e_cause = we ? 4'd7 : 4'd5; end
    else                begin e_fault = 1'b0; e_cause = 4'd0; end
    if (e_fault || we) e_rdata = 32'd0;
    if (early)          lat = 2;
    else if (mode == 3) lat = 2 + int'(TMO);
    else                lat = 3 + waits;

    @(negedge clk);
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; force_deny = deny;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_we = ~we; req_unsigned = ~uns;
    check("pmp_addr", pmp_addr, addr);
    check("ready_busy", 32'(req_ready), 32'd0);
    cyc_idx = 1; bus_n = 0; got = 1'b0; saw = 1'b0;
    for (int t = 0; t < 64 && !got; t++) begin
      if (wb_cyc) begin
        if (!saw) begin
          check("wb_adr", wb_adr, {addr[31:2], 2'b00});
          check("wb_we", 32'(wb_we), 32'(we));
          check("wb_stb", 32'(wb_stb), 32'd1);
          check("wb_sel", 32'(wb_sel), 32'(e_sel));
          check("wb_dat_o", wb_dat_o, e_dato);
        end
        saw = 1'b1;
        if (mode != 3 && bus_n == waits) begin
          wb_ack = (mode != 1); wb_err = (mode != 0); wb_dat_i = rd;
        end
        bus_n++;
      end
      if (resp_valid) begin
        got = 1'b1;
        check("resp_latency", 32'(cyc_idx), 32'(lat));
        check("resp_fault", 32'(resp_fault), 32'(e_fault));
        check("resp_cause", 32'(resp_cause), 32'(e_cause));
        check("resp_rdata", resp_rdata, e_rdata);
        check("cyc_in_resp", 32'(wb_cyc), 32'd0);
      end else begin
        @(posedge clk); #1;
        wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = $urandom; cyc_idx++;
      end
    end
    check("resp_seen", 32'(got), 32'd1);
    check("bus_used", 32'(saw), 32'(!early));
    @(posedge clk); #1;
    check("resp_one_cycle", 32'(resp_valid), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
    force_deny = 1'b0;
  endtask

  // Load that is never answered: hold for 'hold' cycles, then reset mid-BUS.
  task automatic stall_then_reset(input int hold);
    int n, bad;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = MEM_WORD; req_unsigned = 1'b0;
    req_addr = 32'h0000_5000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!wb_cyc && n < 10) begin @(posedge clk); #1; n++; end
    check("stall_reached_bus", 32'(wb_cyc), 32'd1);
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!wb_cyc || resp_valid) bad++;
    end
    check("stall_held", 32'(bad), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("rst_async_cyc", 32'(wb_cyc), 32'd0);
    check("rst_async_stb", 32'(wb_stb), 32'd0);
    @(negedge clk); rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (resp_valid || wb_cyc) bad++;
    end
    check("rst_no_resp", 32'(bad), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int r, nb, mode;
    logic [31:0] a;
    mem_size_t sz;

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = MEM_BYTE;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; force_deny = 1'b0;
    wb_dat_i = '0; wb_ack = 1'b0; wb_err = 1'b0;
    #2;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_fault", 32'(resp_fault), 32'd0);
    check("rst_resp_cause", 32'(resp_cause), 32'd0);
    check("rst_wb_cyc", 32'(wb_cyc), 32'd0);
    check("rst_wb_stb", 32'(wb_stb), 32'd0);
    check("rst_wb_we", 32'(wb_we), 32'd0);
    check("rst_wb_adr", wb_adr, 32'd0);
    check("rst_wb_dat_o", wb_dat_o, 32'd0);
    check("rst_wb_sel", 32'(wb_sel), 32'd0);
    check("rst_pmp_addr", pmp_addr, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk); rst = 1'b1;

    // Terminations while idle must be ignored.
    wb_ack = 1'b1; wb_err = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ack_resp", 32'(resp_valid), 32'd0);
    check("idle_ack_cyc", 32'(wb_cyc), 32'd0);
    wb_ack = 1'b0; wb_err = 1'b0;

    do_tx(1'b0, MEM_BYTE, 1'b0, 32'h0000_1003, 32'h0, 1'b0, 0, 32'h80FF_0000, 0);
    do_tx(1'b1, MEM_HALF, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 1'b0, 0, 32'h1234_5678, 0);
    do_tx(1'b0, MEM_WORD, 1'b0, 32'h0000_3001, 32'h0, 1'b0, 0, 32'h0, 0);
    do_tx(1'b1, MEM_WORD, 1'b0, 32'h0000_4000, 32'hCAFE_F00D, 1'b1, 0, 32'h0, 0);
    do_tx(1'b1, MEM_WORD, 1'b0, 32'h0000_4000, 32'hCAFE_F00D, 1'b0, 0, 32'h0, 2);
    do_tx(1'b0, MEM_HALF, 1'b1, 32'h0000_6002, 32'h0, 1'b0, 3, 32'h9ABC_0000, 0);
    do_tx(1'b0, MEM_HALF, 1'b0, 32'h0000_6001, 32'h0, 1'b0, 0, 32'h0, 0);
    do_tx(1'b0, MEM_WORD, 1'b0, 32'h0000_7000, 32'h0, 1'b0, 1, 32'h0, 1);

    for (int k = 0; k < 40; k++) begin
      sz = mem_size_t'(2'($urandom_range(0, 2)));
      nb = (sz == MEM_BYTE) ? 1 : (sz == MEM_HALF) ? 2 : 4;
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'(a[1:0] & 2'(~(nb - 1)));
      if ($urandom_range(0, 7) == 0) a[31:24] = 8'hFF;
      else a[31:24] = 8'h00;
      r = int'($urandom_range(0, 9));
      mode = (r < 8) ? 0 : (r == 8) ? 1 : 2;
      do_tx(1'($urandom), sz, 1'($urandom), a, $urandom,
            ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)), $urandom, mode);
    end

`ifdef LSU_BUS_TIMEOUT_EN
    do_tx(1'b0, MEM_WORD, 1'b0, 32'h0000_8000, 32'h0, 1'b0, 0, 32'h0, 3);
    stall_then_reset(5);
`else
    stall_then_reset(1000);
`endif

    do_tx(1'b0, MEM_BYTE, 1'b1, 32'h0000_9001, 32'h0, 1'b0, 0, 32'h0000_A500, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
